// File: rtl/memio_pkg.sv
// memio_pkg: shared constants and types for the memory_io slave.
package memio_pkg;

   // Address decode
   localparam int unsigned IO_PAGE_BIT = 22;

   // One-hot IO register select bits (word-address bits [2:0])
   localparam int unsigned IO_LEDS_BIT      = 0;
   localparam int unsigned IO_UART_DAT_BIT  = 1;
   localparam int unsigned IO_UART_CNTL_BIT = 2;

   // Position of the busy flag in a UART_CNTL read
   localparam int unsigned UART_BUSY_RDATA_BIT = 9;

   // UART transmitter states
   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

endpackage

// File: rtl/memory_io_uart_tx.sv
// uart_tx: 8N1 serial transmitter, one frame per accepted start pulse.
// Only present in builds with MEMIO_UART_EN defined.
`ifdef MEMIO_UART_EN
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy
);
   import memio_pkg::*;

   localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

   uart_state_t      state, state_n;
   logic [CNT_W-1:0] baud_cnt, baud_n;
   logic [2:0]       bit_cnt, bit_n;
   logic [7:0]       shreg, shreg_n;
   logic             tx_q, tx_n;
   logic             bit_end;

   assign bit_end = (baud_cnt == BAUD_LAST);

   // Next-state, counters and registered line level
   always_comb begin
      state_n = state;
      baud_n  = baud_cnt;
      bit_n   = bit_cnt;
      shreg_n = shreg;
      tx_n    = tx_q;
      case (state)
         IDLE: begin
            tx_n   = 1'b1;
            baud_n = '0;
            bit_n  = '0;
            if (start) begin
               state_n = START;
               shreg_n = data;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               baud_n  = '0;
               state_n = DATA;
               tx_n    = shreg[0];
            end else begin
               baud_n = baud_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_n = '0;
               if (bit_cnt == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n   = bit_cnt + 3'd1;
                  shreg_n = {1'b0, shreg[7:1]};
                  tx_n    = shreg[1];
               end
            end else begin
               baud_n = baud_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_n  = '0;
               state_n = IDLE;
            end else begin
               baud_n = baud_cnt + CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register; reset aborts any frame and idles the line
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_cnt  <= bit_n;
         shreg    <= shreg_n;
         tx_q     <= tx_n;
      end
   end

   assign tx   = tx_q;
   assign busy = (state != IDLE);

endmodule
`endif

// File: rtl/memory_io.sv
// memory_io: RAM / LED / UART slave on the RV32I core memory port.
// Define MEMIO_UART_EN to build the UART transmitter; otherwise the
// line is held idle and UART_DAT writes are ignored.
module memory_io #(
   parameter int unsigned MEM_WORDS    = 1536,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic        mem_rstrb,
   output logic [31:0] mem_rdata,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wmask,
   output logic [4:0]  leds,
   output logic        uart_tx,
   output logic        uart_busy
);
   import memio_pkg::*;

   localparam int unsigned IDX_W = $clog2(MEM_WORDS);

   if (CLKS_PER_BIT < 2) begin : g_cpb_check
      $error("memory_io: CLKS_PER_BIT must be at least 2");
   end

   logic [31:0] ram [MEM_WORDS];

   logic        io_page;
   logic [2:0]  io_sel;
   logic [31:0] ram_idx;
   logic        ram_hit;
   logic        wr;
   logic [31:0] ram_rdata;
   logic [31:0] io_rdata;
   logic        unused_bits;

   assign io_page = mem_addr[IO_PAGE_BIT];
   assign io_sel  = io_page ? mem_addr[4:2] : 3'b000;
   assign ram_idx = {12'b0, mem_addr[21:2]};
   assign ram_hit = !io_page && (ram_idx < MEM_WORDS);
   assign wr      = |mem_wmask;

   assign unused_bits = &{1'b0, mem_addr[31:23], mem_addr[1:0], io_sel[IO_UART_DAT_BIT]};

   // RAM read port; out-of-range indices read as zero instead of wrapping
   always_comb begin
      ram_rdata = '0;
      if (ram_hit) begin
         ram_rdata = ram[ram_idx[IDX_W-1:0]];
      end
   end

   // IO read mux: OR of every selected register
   always_comb begin
      io_rdata = '0;
      if (io_sel[IO_LEDS_BIT]) begin
         io_rdata = io_rdata | {27'b0, leds};
      end
      if (io_sel[IO_UART_CNTL_BIT]) begin
         io_rdata[UART_BUSY_RDATA_BIT] = uart_busy;
      end
   end

   // Byte-lane RAM writes, committed on the request edge
   always_ff @(posedge clk) begin
      if (ram_hit && wr) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (mem_wmask[b]) begin
               ram[ram_idx[IDX_W-1:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   // Registered read data (held between strobes) and LED register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_rdata <= '0;
         leds      <= '0;
      end else begin
         if (mem_rstrb) begin
            mem_rdata <= io_page ? io_rdata : ram_rdata;
         end
         if (io_sel[IO_LEDS_BIT] && mem_wmask[0]) begin
            leds <= mem_wdata[4:0];
         end
      end
   end

`ifdef MEMIO_UART_EN
   logic uart_start;

   assign uart_start = io_sel[IO_UART_DAT_BIT] && mem_wmask[0] && !uart_busy;

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_tx (
      .clk   (clk),
      .reset (reset),
      .start (uart_start),
      .data  (mem_wdata[7:0]),
      .tx    (uart_tx),
      .busy  (uart_busy)
   );
`else
   assign uart_tx   = 1'b1;
   assign uart_busy = 1'b0;
`endif

endmodule

// File: tb/tb_memory_io.sv
// tb_memory_io: table vectors, random traffic against a reference model,
// and hand-written UART / reset sequences for memory_io.
module tb_memory_io;

   localparam int unsigned MW  = 1536;
   localparam int unsigned CPB = 4;
`ifdef MEMIO_UART_EN
   localparam bit UART_EN = 1'b1;
`else
   localparam bit UART_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_rdata;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [4:0]  leds;
   logic        uart_tx;
   logic        uart_busy;

   memory_io #(
      .MEM_WORDS    (MW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_addr  (mem_addr),
      .mem_rstrb (mem_rstrb),
      .mem_rdata (mem_rdata),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .leds      (leds),
      .uart_tx   (uart_tx),
      .uart_busy (uart_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   logic [31:0] ref_ram [int unsigned];
   logic [4:0]  ref_leds;

   typedef struct {
      bit          is_read;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [31:0] a, input bit busy);
      logic [31:0] v;
      int unsigned idx;
      v = '0;
      if (a[22]) begin
         if (a[2]) v = v | {27'b0, ref_leds};
         if (a[4] && busy) v = v | 32'h0000_0200;
      end else begin
         idx = {12'b0, a[21:2]};
         if (idx < MW) v = ref_ram.exists(idx) ? ref_ram[idx] : 'x;
      end
      return v;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int unsigned idx;
      logic [31:0] w;
      if (!a[22]) begin
         idx = {12'b0, a[21:2]};
         if (idx < MW) begin
            w = ref_ram.exists(idx) ? ref_ram[idx] : 'x;
            for (int b = 0; b < 4; b++) begin
               if (m[b]) w[8*b +: 8] = d[8*b +: 8];
            end
            if (m != 4'b0) ref_ram[idx] = w;
         end
      end else if (a[2] && m[0]) begin
         ref_leds = d[4:0];
      end
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      @(negedge clk);
      mem_addr  = a;
      mem_wdata = d;
      mem_wmask = m;
      mem_rstrb = 1'b0;
      model_write(a, d, m);
      @(negedge clk);
      mem_wmask = 4'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
      @(negedge clk);
      mem_addr  = a;
      mem_rstrb = 1'b1;
      @(negedge clk);
      mem_rstrb = 1'b0;
      r = mem_rdata;
   endtask

   // Called at the sample point right after the edge that accepted a write of d
   task automatic run_frame(input logic [7:0] d, input bit extras);
      logic [9:0] bits;
      bits = {1'b1, d, 1'b0};
      for (int k = 0; k < 10 * CPB; k++) begin
         check($sformatf("tx[%0d]", k), {31'b0, uart_tx}, {31'b0, UART_EN ? bits[k / CPB] : 1'b1});
         check($sformatf("busy[%0d]", k), {31'b0, uart_busy}, {31'b0, UART_EN});
         if (extras) begin
            if (k == 10) begin
               mem_addr  = 32'h0040_0010;
               mem_rstrb = 1'b1;
            end
            if (k == 11) begin
               mem_rstrb = 1'b0;
               check("cntl_mid_frame", mem_rdata, UART_EN ? 32'h0000_0200 : 32'h0);
            end
            if (k == 15) begin
               mem_addr  = 32'h0040_0008;
               mem_wdata = 32'h0000_00FF;
               mem_wmask = 4'b0001;
            end
            if (k == 16) mem_wmask = 4'b0;
         end
         @(negedge clk);
      end
      check("tx_after_frame", {31'b0, uart_tx}, 32'h1);
      check("busy_after_frame", {31'b0, uart_busy}, 32'h0);
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] a, d, e, last;
      logic [3:0]  m;
      bit          s, ok;
      int unsigned sel;

      reset     = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wmask = '0;
      mem_rstrb = 1'b0;
      ref_leds  = '0;

      // Reset state
      #1 reset = 1'b1;
      #2;
      check("reset_rdata", mem_rdata, 32'h0);
      check("reset_leds", {27'b0, leds}, 32'h0);
      check("reset_tx", {31'b0, uart_tx}, 32'h1);
      check("reset_busy", {31'b0, uart_busy}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Directed vectors
      vecs.push_back('{0, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0});
      vecs.push_back('{1, 32'h0000_0100, 32'h0,         4'b0000, 32'hDEAD_BEEF});
      vecs.push_back('{0, 32'h0000_0100, 32'h00AA_0000, 4'b0100, 32'h0});
      vecs.push_back('{1, 32'h0000_0100, 32'h0,         4'b0000, 32'hDEAA_BEEF});
      vecs.push_back('{0, 32'h0000_0100, 32'h1234_1234, 4'b0011, 32'h0});
      vecs.push_back('{1, 32'h0000_0100, 32'h0,         4'b0000, 32'hDEAA_1234});
      vecs.push_back('{0, 32'h0040_0004, 32'h0000_001F, 4'b0001, 32'h0});
      vecs.push_back('{1, 32'h0040_0004, 32'h0,         4'b0000, 32'h0000_001F});
      vecs.push_back('{0, 32'h0000_0000, 32'h1111_1111, 4'b1111, 32'h0});
      vecs.push_back('{0, MW * 4,        32'hCAFE_F00D, 4'b1111, 32'h0});
      vecs.push_back('{1, MW * 4,        32'h0,         4'b0000, 32'h0});
      vecs.push_back('{1, 32'h0000_0000, 32'h0,         4'b0000, 32'h1111_1111});
      vecs.push_back('{1, 32'h003F_FFFC, 32'h0,         4'b0000, 32'h0});
      vecs.push_back('{1, 32'h0040_0000, 32'h0,         4'b0000, 32'h0});
      vecs.push_back('{1, 32'h0040_0008, 32'h0,         4'b0000, 32'h0});
      vecs.push_back('{1, 32'h0040_0010, 32'h0,         4'b0000, 32'h0});
      vecs.push_back('{0, 32'h0040_0010, 32'hFFFF_FFFF, 4'b1111, 32'h0});
      vecs.push_back('{1, 32'h0040_0004, 32'h0,         4'b0000, 32'h0000_001F});

      foreach (vecs[i]) begin
         if (vecs[i].is_read) begin
            bus_read(vecs[i].addr, r);
            check($sformatf("vec%0d", i), r, vecs[i].exp);
         end else begin
            bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].mask);
         end
      end
      check("leds_out", {27'b0, leds}, 32'h0000_001F);

      // Read data holds while no strobe is issued
      bus_read(32'h0000_0100, r);
      mem_addr = 32'h0000_0000;
      repeat (3) @(negedge clk);
      check("rdata_hold", mem_rdata, 32'hDEAA_1234);

      // Same-cycle strobe and write to one word returns the old contents
      bus_write(32'h0000_0200, 32'h0102_0304, 4'b1111);
      @(negedge clk);
      mem_addr  = 32'h0000_0200;
      mem_wdata = 32'hA5A5_A5A5;
      mem_wmask = 4'b1111;
      mem_rstrb = 1'b1;
      model_write(32'h0000_0200, 32'hA5A5_A5A5, 4'b1111);
      @(negedge clk);
      mem_wmask = 4'b0;
      mem_rstrb = 1'b0;
      check("rmw_old", mem_rdata, 32'h0102_0304);
      bus_read(32'h0000_0200, r);
      check("rmw_new", r, 32'hA5A5_A5A5);

      // Random traffic against the model
      for (int unsigned i = 0; i < 16; i++) begin
         bus_write(32'(i * 4), $urandom, 4'b1111);
      end
      bus_read(32'h0, r);
      last = exp_read(32'h0, 1'b0);
      check("rand_prefill", r, last);
      @(negedge clk);
      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            6:       a = 32'((MW + $urandom_range(0, 7)) * 4);
            7:       a = 32'h0040_0004;
            8:       a = 32'h0040_0000;
            9:       a = 32'h0040_0010;
            default: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         endcase
         d = $urandom;
         m = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0;
         s = ($urandom_range(0, 1) == 1);
         e = s ? exp_read(a, 1'b0) : last;
         model_write(a, d, m);
         mem_addr  = a;
         mem_wdata = d;
         mem_wmask = m;
         mem_rstrb = s;
         @(negedge clk);
         check($sformatf("rand%0d_rdata", i), mem_rdata, e);
         check($sformatf("rand%0d_leds", i), {27'b0, leds}, {27'b0, ref_leds});
         last = e;
      end
      mem_wmask = 4'b0;
      mem_rstrb = 1'b0;

      // UART frame with a mid-frame status read and a dropped write
      @(negedge clk);
      mem_addr  = 32'h0040_0008;
      mem_wdata = 32'h0000_0055;
      mem_wmask = 4'b0001;
      @(negedge clk);
      mem_wmask = 4'b0;
      run_frame(8'h55, 1'b1);
      // Write in the first idle cycle after busy falls
      mem_addr  = 32'h0040_0008;
      mem_wdata = 32'h0000_00A3;
      mem_wmask = 4'b0001;
      @(negedge clk);
      mem_wmask = 4'b0;
      run_frame(8'hA3, 1'b0);

      // Reset in the middle of a frame
      bus_write(32'h0040_0004, 32'h0000_0015, 4'b0001);
      bus_read(32'h0000_0100, r);
      check("pre_reset_rdata", r, exp_read(32'h0000_0100, 1'b0));
      @(negedge clk);
      mem_addr  = 32'h0040_0008;
      mem_wdata = 32'h0000_003C;
      mem_wmask = 4'b0001;
      @(negedge clk);
      mem_wmask = 4'b0;
      repeat (10) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_tx", {31'b0, uart_tx}, 32'h1);
      check("midrst_busy", {31'b0, uart_busy}, 32'h0);
      check("midrst_leds", {27'b0, leds}, 32'h0);
      check("midrst_rdata", mem_rdata, 32'h0);
      ref_leds = '0;
      @(negedge clk);
      reset = 1'b0;
      ok = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || uart_busy !== 1'b0) ok = 1'b0;
      end
      check("post_reset_idle", {31'b0, ok}, 32'h1);
      bus_read(32'h0000_0100, r);
      check("post_reset_ram", r, 32'hDEAA_1234);
      bus_read(32'h0000_0200, r);
      check("post_reset_ram2", r, 32'hA5A5_A5A5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/memory_io.md
# memory_io

Memory and I/O slave that sits directly on the RV32I core's memory port. It decodes the core's address, read strobe, write data and write mask into three targets: a byte-writable word RAM, an LED register and a UART transmitter. It returns registered read data one cycle after each read strobe, which matches the core's strobe-then-wait fetch and load sequence.

## Interface
Parameters:
- MEM_WORDS, 1536: RAM depth in 32-bit words.
- CLKS_PER_BIT, 868: UART bit period in clk cycles. Must be at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_addr  in  32  byte address from the core.
- mem_rstrb  in  1  read strobe; one cycle per access.
- mem_rdata  out  32  registered read data.
- mem_wdata  in  32  write data, already lane-replicated by the core.
- mem_wmask  in  4  byte write enables; any bit set means a write.
- leds  out  5  LED register.
- uart_tx  out  1  serial line; idles high.
- uart_busy  out  1  transmitter active.

## Operation
- Page select:
  - mem_addr[22]=0 selects the RAM page. Word index is mem_addr[21:2].
  - mem_addr[22]=1 selects the IO page. Register select is one-hot on word-address bits [2:0] (mem_addr[4:2]).
  - Bit 0 is LEDS (0x400004), bit 1 is UART_DAT (0x400008), bit 2 is UART_CNTL (0x400010).
- RAM read: on mem_rstrb, mem_rdata <= ram[index].
- RAM write: for each set bit k of mem_wmask, ram[index] byte k <= mem_wdata byte k. This happens on the same edge as the request.
- RAM out-of-range access (index ≥ MEM_WORDS): reads return 0 and writes are ignored. The index never wraps.
- Same-cycle rstrb and write to the same word: the read returns the pre-write contents.
- IO reads: on mem_rstrb, mem_rdata <= OR of the selected registers.
  - LEDS reads {27'b0, leds}.
  - UART_DAT reads 0.
  - UART_CNTL reads {22'b0, uart_busy, 9'b0}.
  - No select bit set reads 0.
- IO writes:
  - LEDS: when mem_wmask[0] is set, leds <= mem_wdata[4:0].
  - UART_DAT: when mem_wmask[0] is set, the write starts a frame with byte mem_wdata[7:0], but only if uart_busy=0. A write while busy is dropped silently.
  - UART_CNTL is read-only; writes are ignored.
- UART frame: 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1). Each bit lasts CLKS_PER_BIT cycles.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on an accepted write.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→STOP after 8 bit periods. A 3-bit bit counter is used.
  - STOP→IDLE after CLKS_PER_BIT cycles.
- uart_busy = (state != IDLE).
- Baud counter width is $clog2(CLKS_PER_BIT). It reloads at each bit boundary.
- mem_rdata holds its value when mem_rstrb=0. The core samples it during wait cycles.

## Timing
- Read latency is 1 cycle. A strobe at edge N means data is valid after edge N and held until the next strobe.
- Write latency is 0. A write is committed at the edge where the mask is non-zero, so a read strobed on the next cycle sees the new data.
- UART timing:
  - uart_tx falls and uart_busy rises at the edge that captures the accepted UART_DAT write.
  - uart_busy falls exactly 10×CLKS_PER_BIT cycles later, at the end of the stop bit.
  - A new write in that same cycle is accepted.
- Reset values: mem_rdata=0, leds=0, uart_tx=1, uart_busy=0, FSM=IDLE, counters=0. RAM contents are not reset.
- Reset asserted mid-frame aborts the frame immediately (asynchronously) with uart_tx=1. No partial retransmit follows reset release.

## Configuration
- MEMIO_UART_EN defined: the UART transmitter is built as described above.
- MEMIO_UART_EN undefined:
  - No transmitter logic is built.
  - uart_tx is tied to 1 and uart_busy to 0.
  - UART_DAT writes are ignored.
  - UART_CNTL reads 0.
  - The RAM and LEDS behave identically in both configurations.

## Structure
- Package memio_pkg holds:
  - IO_PAGE_BIT=22.
  - IO_LEDS_BIT=0, IO_UART_DAT_BIT=1, IO_UART_CNTL_BIT=2.
  - UART_BUSY_RDATA_BIT=9.
  - The uart_state_t enum (IDLE, START, DATA, STOP).
- Sub-module uart_tx (ports: clk, reset, start, data[7:0], tx, busy, parameter CLKS_PER_BIT).
  - Instantiated only under MEMIO_UART_EN.
  - The top level keeps address decode, RAM, LEDs and the read mux.

## Test plan
- RAM write/read: write 0xDEADBEEF with mask 1111 to 0x100, strobe a read of 0x100 → mem_rdata=0xDEADBEEF one cycle later.
- Byte lanes: after the above, write mask 0100 with wdata 0x00AA0000 to 0x100 → read returns 0xDEAABEEF. Then mask 0011 with wdata 0x12341234 → 0xDEAA1234.
- LEDs and out-of-range:
  - Write 0x1F to 0x400004 → leds=5'h1F, and a read of 0x400004 returns 0x1F.
  - A read at word index MEM_WORDS returns 0.
- UART frame (CLKS_PER_BIT=4): write 0x55 to 0x400008 →
  - uart_tx is low for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4.
  - uart_busy is high for exactly 40 cycles.
  - A UART_CNTL read mid-frame returns 0x200.
- Busy drop: a second write of 0xFF issued mid-frame → ignored, and the line returns to idle after the first frame. A write issued on the busy-fall cycle is transmitted.
- Reset mid-frame: assert reset at cycle 10 of a frame → uart_tx=1, uart_busy=0, leds=0 and mem_rdata=0 immediately, while RAM data written earlier is still readable after release.
